// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF receive path.
package spdif_pkg;

    // Pulse width classes, in unit intervals (UI = half bit cell)
    typedef enum logic [1:0] {PC_S, PC_M, PC_L, PC_BAD} pulse_e;

    // Preamble kinds; PRE_NONE marks an unrecognised pulse sequence
    typedef enum logic [1:0] {PRE_B, PRE_M, PRE_W, PRE_NONE} pre_e;

    // Framing FSM states
    typedef enum logic [1:0] {ST_HUNT, ST_PRE, ST_DATA} state_e;

    localparam int SLOT_AUDIO = 4;
    localparam int SLOT_V     = 28;
    localparam int SLOT_U     = 29;
    localparam int SLOT_C     = 30;
    localparam int SLOT_P     = 31;

    // Identify a preamble from the three pulses that follow its leading L
    function automatic pre_e decode_pre(pulse_e p2, pulse_e p3, pulse_e p4);
        pre_e k;
        k = PRE_NONE;
        if (p2 == PC_S && p3 == PC_S && p4 == PC_L) k = PRE_B;
        if (p2 == PC_L && p3 == PC_S && p4 == PC_S) k = PRE_M;
        if (p2 == PC_M && p3 == PC_S && p4 == PC_M) k = PRE_W;
        return k;
    endfunction

endpackage

// File: rtl/spdif_audio_decoder_if.sv
// Decoded-subframe stream from the receiver to downstream audio logic.
interface spdif_audio_decoder_if #(
    parameter int audio_width = 16
);
    logic                   o_valid;
    logic                   o_ready;
    logic [audio_width-1:0] o_audio;
    logic                   o_is_left;
    logic                   o_is_error;
    logic                   o_block_start;
    logic                   o_user;
    logic                   o_channel_status;
    logic                   o_locked;
    logic                   o_overrun;

    modport master (
        output o_valid, o_audio, o_is_left, o_is_error, o_block_start,
               o_user, o_channel_status, o_locked, o_overrun,
        input  o_ready
    );

    modport slave (
        input  o_valid, o_audio, o_is_left, o_is_error, o_block_start,
               o_user, o_channel_status, o_locked, o_overrun,
        output o_ready
    );
endinterface

// File: rtl/spdif_pulse_classifier.sv
// Line front end: synchronise, find transitions, measure and classify the
// time between them. One registered pulse_valid per transition.
module spdif_pulse_classifier
    import spdif_pkg::*;
#(
    parameter int unit_cycles = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   spdif,
    output logic   pulse_valid,
    output pulse_e pulse_class,
    output logic   timeout
);
    localparam int SAT  = 4 * unit_cycles;
    localparam int CW   = $clog2(SAT + 1);
    localparam int TH_S = (3 * unit_cycles) / 2;
    localparam int TH_M = (5 * unit_cycles) / 2;
    localparam int TH_L = (7 * unit_cycles) / 2;

    logic [2:0]    sync;   // [1:0] synchroniser, [2] previous sampled level
    logic          edge_det;
    logic [CW-1:0] width;  // cycles since last transition, saturating

    assign edge_det = sync[1] ^ sync[2];

    function automatic pulse_e classify(logic [CW-1:0] w);
        if (w < CW'(TH_S)) return PC_S;
        if (w < CW'(TH_M)) return PC_M;
        if (w < CW'(TH_L)) return PC_L;
        return PC_BAD;
    endfunction

    // Synchronise, count, and register the class of each completed pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync        <= '0;
            width       <= '0;
            pulse_valid <= 1'b0;
            pulse_class <= PC_S;
            timeout     <= 1'b0;
        end else begin
            sync        <= {sync[1:0], spdif};
            pulse_valid <= edge_det;
            pulse_class <= classify(width);
            // Fires once, on the cycle the counter reaches saturation
            timeout     <= !edge_det && (width == CW'(SAT - 1));
            if (edge_det)
                width <= CW'(1);
            else if (width != CW'(SAT))
                width <= width + CW'(1);
        end
    end

endmodule

// File: rtl/spdif_audio_decoder.sv
// S/PDIF receiver: preamble/bit framing FSM, parity, lock tracking and a
// single-entry output register with valid/ready handshake.
module spdif_audio_decoder
    import spdif_pkg::*;
#(
    parameter int audio_width = 16,
    parameter int unit_cycles = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spdif,
    spdif_audio_decoder_if.master bus
);
    logic        pv, tmo;
    pulse_e      pc;

    state_e      state_q, state_d;
    logic [1:0]  pre_idx;    // preamble pulse expected next (0 = leading L)
    pulse_e      p2, p3;
    pre_e        pre_kind;
    logic        have_s;     // first half of a '1' cell already seen
    logic [4:0]  slot;
    logic [26:0] sr;         // slots 4..30, newest at the top
    logic        is_left_q, blk_q;
    logic [1:0]  good_cnt;

    logic        bit_valid, frame_err, sub_done, par_err;
    logic [27:0] word_full;  // slots 4..31, meaningful on the final bit

    spdif_pulse_classifier #(.unit_cycles(unit_cycles)) u_cls (
        .clk        (clk),
        .reset      (reset),
        .spdif      (spdif),
        .pulse_valid(pv),
        .pulse_class(pc),
        .timeout    (tmo)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_HUNT;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (tmo) begin
            state_d = ST_HUNT;
        end else if (pv) begin
            case (state_q)
                ST_HUNT: if (pc == PC_L) state_d = ST_PRE;
                ST_PRE: begin
                    if (frame_err)             state_d = ST_HUNT;
                    else if (pre_idx == 2'd3)  state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (sub_done)       state_d = ST_PRE;
                    else if (frame_err) state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // FSM outputs: per-pulse decode strobes
    always_comb begin
        pre_kind  = decode_pre(p2, p3, pc);
        word_full = {have_s, sr};
        par_err   = ^word_full;
        bit_valid = 1'b0;
        frame_err = 1'b0;
        if (pv) begin
            case (state_q)
                ST_PRE:
                    frame_err = (pre_idx == 2'd0 && pc != PC_L) ||
                                (pre_idx == 2'd3 && pre_kind == PRE_NONE);
                ST_DATA: begin
                    bit_valid = have_s ? (pc == PC_S) : (pc == PC_M);
                    // A lone S is the legal first half of a '1'
                    frame_err = !bit_valid && (have_s || pc != PC_S);
                end
                default: ;
            endcase
        end
        sub_done = bit_valid && (slot == 5'(SLOT_P));
    end

    // Preamble capture and bit shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_idx   <= '0;
            p2        <= PC_S;
            p3        <= PC_S;
            have_s    <= 1'b0;
            slot      <= '0;
            sr        <= '0;
            is_left_q <= 1'b0;
            blk_q     <= 1'b0;
        end else if (pv && !tmo) begin
            case (state_q)
                ST_HUNT: pre_idx <= 2'd1;
                ST_PRE: begin
                    pre_idx <= pre_idx + 2'd1;
                    if (pre_idx == 2'd1) p2 <= pc;
                    if (pre_idx == 2'd2) p3 <= pc;
                    if (pre_idx == 2'd3) begin
                        is_left_q <= (pre_kind != PRE_W);
                        blk_q     <= (pre_kind == PRE_B);
                        slot      <= 5'(SLOT_AUDIO);
                        have_s    <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bit_valid) begin
                        sr     <= {have_s, sr[26:1]};
                        have_s <= 1'b0;
                        slot   <= slot + 5'd1;
                        // Slot 31's last pulse ends on the next preamble's
                        // leading edge, so its leading L is still to come
                        if (sub_done) pre_idx <= 2'd0;
                    end else begin
                        have_s <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lock: two consecutive clean subframes; any error drops it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_cnt     <= '0;
            bus.o_locked <= 1'b0;
        end else if (tmo || frame_err || (sub_done && par_err)) begin
            good_cnt     <= '0;
            bus.o_locked <= 1'b0;
        end else if (sub_done) begin
            good_cnt     <= (good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1;
            bus.o_locked <= (good_cnt != 2'd0);
        end
    end

    // Output register: hold until accepted, drop newcomers while blocked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.o_valid          <= 1'b0;
            bus.o_audio          <= '0;
            bus.o_is_left        <= 1'b0;
            bus.o_is_error       <= 1'b0;
            bus.o_block_start    <= 1'b0;
            bus.o_user           <= 1'b0;
            bus.o_channel_status <= 1'b0;
            bus.o_overrun        <= 1'b0;
        end else begin
            bus.o_overrun <= 1'b0;
            if (sub_done) begin
                if (!bus.o_valid || bus.o_ready) begin
                    bus.o_valid          <= 1'b1;
                    bus.o_audio          <= word_full[SLOT_V-SLOT_AUDIO-1 -: audio_width];
                    bus.o_is_left        <= is_left_q;
                    bus.o_is_error       <= par_err | word_full[SLOT_V-SLOT_AUDIO];
                    bus.o_block_start    <= blk_q;
                    bus.o_user           <= word_full[SLOT_U-SLOT_AUDIO];
                    bus.o_channel_status <= word_full[SLOT_C-SLOT_AUDIO];
                end else begin
                    bus.o_overrun <= 1'b1;
                end
            end else if (bus.o_valid && bus.o_ready) begin
                bus.o_valid <= 1'b0;
            end
        end
    end

endmodule
